// File: rtl/game_state_manager.sv
// game_state_manager: score/lives/level/alien bookkeeping and play/freeze/game-over sequencing
module game_state_manager #(
  parameter int LIVES_INIT    = 3,
  parameter int ALIENS_TOTAL  = 40,
  parameter int ALIEN_POINTS  = 10,
  parameter int SHIP_POINTS   = 100,
  parameter int FREEZE_FRAMES = 60
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        startKey,
  input  logic        col_alien,
  input  logic        col_ship,
  input  logic        col_player,
  input  logic        invasion,
  output logic [2:0]  state,
  output logic [15:0] score,
  output logic [2:0]  lives,
  output logic [3:0]  level,
  output logic [5:0]  aliensLeft,
  output logic        freeze,
  output logic        playerHitPulse,
  output logic        levelUpPulse
);
  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] PLAY        = 3'd1;
  localparam logic [2:0] FREEZE      = 3'd2;
  localparam logic [2:0] LEVEL_CLEAR = 3'd3;
  localparam logic [2:0] GAMEOVER    = 3'd4;
  logic [2:0]  state_q, state_d, lives_q, lives_d;
  logic [15:0] score_q, score_d;
  logic [3:0]  level_q, level_d;
  logic [5:0]  aliens_q, aliens_d, aliens_nx;
  logic [7:0]  cnt_q, cnt_d;
  logic        freeze_q, hit_q, hit_d, lvl_q, lvl_d, start_q;
  logic [3:0]  flag_q, flag_d, col, acc;
  logic        start_edge, alien_hit, fatal, exit_cnt;
  logic [16:0] sum;
  assign col        = {invasion, col_player, col_ship, col_alien};
  assign acc        = col & (~flag_q | {4{startOfFrame}});
  assign flag_d     = acc | (flag_q & ~{4{startOfFrame}});
  assign start_edge = startKey & ~start_q;
  assign alien_hit  = acc[0] && aliens_q != 6'd0;
  assign aliens_nx  = aliens_q - 6'(alien_hit);
  assign fatal      = acc[2] && lives_q <= 3'd1;
  assign exit_cnt   = startOfFrame && cnt_q == 8'd1;
  assign sum        = {1'b0, score_q} + (alien_hit ? 17'(ALIEN_POINTS) : 17'd0) + (acc[1] ? 17'(SHIP_POINTS) : 17'd0);
  // Next-state rules for every game state; events only take effect in PLAY
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    lives_d  = lives_q;
    level_d  = level_q;
    aliens_d = aliens_q;
    cnt_d    = cnt_q;
    hit_d    = 1'b0;
    lvl_d    = 1'b0;
    if (state_q == IDLE) begin
      state_d = start_edge ? PLAY : IDLE;
    end else if (state_q == PLAY) begin
      if (acc[3]) begin
        lives_d = 3'd0;
        state_d = GAMEOVER;
      end else begin
        score_d  = sum[16] ? 16'hFFFF : sum[15:0];
        aliens_d = aliens_nx;
        if (acc[2]) begin
          lives_d = fatal ? 3'd0 : lives_q - 3'd1;
          hit_d   = 1'b1;
        end
        if (fatal) begin
          state_d = GAMEOVER;
        end else if (alien_hit && aliens_nx == 6'd0) begin
          state_d = LEVEL_CLEAR;
          cnt_d   = 8'(FREEZE_FRAMES);
        end else if (acc[2]) begin
          state_d = FREEZE;
          cnt_d   = 8'(FREEZE_FRAMES);
        end
      end
    end else if (state_q == FREEZE || state_q == LEVEL_CLEAR) begin
      cnt_d = startOfFrame ? cnt_q - 8'd1 : cnt_q;
      if (exit_cnt) begin
        state_d = PLAY;
        if (state_q == LEVEL_CLEAR) begin
          level_d  = level_q == 4'd15 ? 4'd15 : level_q + 4'd1;
          aliens_d = 6'(ALIENS_TOTAL);
          lvl_d    = 1'b1;
        end
      end
    end else if (start_edge) begin
      state_d  = PLAY;
      score_d  = 16'd0;
      lives_d  = 3'(LIVES_INIT);
      level_d  = 4'd1;
      aliens_d = 6'(ALIENS_TOTAL);
    end
  end
  // State registers with asynchronous active-low reset; freeze tracks the next state so it is registered
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      score_q  <= 16'd0;
      lives_q  <= 3'(LIVES_INIT);
      level_q  <= 4'd1;
      aliens_q <= 6'(ALIENS_TOTAL);
      cnt_q    <= 8'd0;
      freeze_q <= 1'b1;
      hit_q    <= 1'b0;
      lvl_q    <= 1'b0;
      start_q  <= 1'b0;
      flag_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      level_q  <= level_d;
      aliens_q <= aliens_d;
      cnt_q    <= cnt_d;
      freeze_q <= state_d != PLAY;
      hit_q    <= hit_d;
      lvl_q    <= lvl_d;
      start_q  <= startKey;
      flag_q   <= flag_d;
    end
  end
  assign state          = state_q;
  assign score          = score_q;
  assign lives          = lives_q;
  assign level          = level_q;
  assign aliensLeft     = aliens_q;
  assign freeze         = freeze_q;
  assign playerHitPulse = hit_q;
  assign levelUpPulse   = lvl_q;
endmodule

// File: tb/tb_game_state_manager.sv
// tb_game_state_manager: directed checks of game rule sequencing
module tb_game_state_manager;
  logic clk = 1'b0, resetN = 1'b0, sof = 1'b0, start_key = 1'b0;
  logic c_alien = 1'b0, c_ship = 1'b0, c_player = 1'b0, inv = 1'b0;
  logic [2:0] state, lives, state2, lives2;
  logic [15:0] score, score2;
  logic [3:0] level, level2;
  logic [5:0] aliens, aliens2;
  logic freeze, hit, lvlup, freeze2, hit2, lvlup2;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  game_state_manager u_dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .startKey(start_key),
    .col_alien(c_alien), .col_ship(c_ship), .col_player(c_player), .invasion(inv),
    .state(state), .score(score), .lives(lives), .level(level), .aliensLeft(aliens),
    .freeze(freeze), .playerHitPulse(hit), .levelUpPulse(lvlup)
  );
  game_state_manager #(.ALIENS_TOTAL(2)) u_dut2 (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .startKey(start_key),
    .col_alien(c_alien), .col_ship(c_ship), .col_player(c_player), .invasion(inv),
    .state(state2), .score(score2), .lives(lives2), .level(level2), .aliensLeft(aliens2),
    .freeze(freeze2), .playerHitPulse(hit2), .levelUpPulse(lvlup2)
  );
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_sof();
    sof = 1'b1;
    cyc(1);
    sof = 1'b0;
    cyc(1);
  endtask
  task automatic press_start();
    start_key = 1'b1;
    cyc(1);
    start_key = 1'b0;
  endtask
  task automatic test_reset();
    resetN = 1'b0;
    cyc(2);
    n_checks += 8;
    if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    if (score !== 16'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score); end
    if (lives !== 3'd3) begin n_fail++; $display("FAIL reset_lives: got %0d expected 3", lives); end
    if (level !== 4'd1) begin n_fail++; $display("FAIL reset_level: got %0d expected 1", level); end
    if (aliens !== 6'd40) begin n_fail++; $display("FAIL reset_aliens: got %0d expected 40", aliens); end
    if (freeze !== 1'b1) begin n_fail++; $display("FAIL reset_freeze: got %0d expected 1", freeze); end
    if ({hit, lvlup} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b expected 00", {hit, lvlup}); end
    if (aliens2 !== 6'd2) begin n_fail++; $display("FAIL reset_aliens2: got %0d expected 2", aliens2); end
    resetN = 1'b1;
    cyc(1);
  endtask
  task automatic test_start();
    cyc(2);
    n_checks++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL idle_hold: got %0d expected 0", state); end
    press_start();
    n_checks += 2;
    if (state !== 3'd1) begin n_fail++; $display("FAIL start_state: got %0d expected 1", state); end
    if (freeze !== 1'b0) begin n_fail++; $display("FAIL start_freeze: got %0d expected 0", freeze); end
  endtask
  task automatic test_alien_hold();
    pulse_sof();
    c_alien = 1'b1;
    cyc(200);
    c_alien = 1'b0;
    n_checks += 2;
    if (score !== 16'd10) begin n_fail++; $display("FAIL hold_score: got %0d expected 10", score); end
    if (aliens !== 6'd39) begin n_fail++; $display("FAIL hold_aliens: got %0d expected 39", aliens); end
    pulse_sof();
    c_alien = 1'b1;
    cyc(1);
    c_alien = 1'b0;
    n_checks += 2;
    if (score !== 16'd20) begin n_fail++; $display("FAIL second_score: got %0d expected 20", score); end
    if (aliens !== 6'd38) begin n_fail++; $display("FAIL second_aliens: got %0d expected 38", aliens); end
  endtask
  task automatic test_simultaneous();
    pulse_sof();
    c_alien = 1'b1;
    c_ship = 1'b1;
    cyc(1);
    c_alien = 1'b0;
    c_ship = 1'b0;
    n_checks += 2;
    if (score !== 16'd130) begin n_fail++; $display("FAIL simul_score: got %0d expected 130", score); end
    if (aliens !== 6'd37) begin n_fail++; $display("FAIL simul_aliens: got %0d expected 37", aliens); end
  endtask
  task automatic test_player_freeze();
    pulse_sof();
    c_player = 1'b1;
    cyc(1);
    c_player = 1'b0;
    n_checks += 4;
    if (lives !== 3'd2) begin n_fail++; $display("FAIL hit_lives: got %0d expected 2", lives); end
    if (hit !== 1'b1) begin n_fail++; $display("FAIL hit_pulse: got %0d expected 1", hit); end
    if (state !== 3'd2) begin n_fail++; $display("FAIL hit_state: got %0d expected 2", state); end
    if (freeze !== 1'b1) begin n_fail++; $display("FAIL hit_freeze: got %0d expected 1", freeze); end
    cyc(1);
    n_checks++;
    if (hit !== 1'b0) begin n_fail++; $display("FAIL hit_pulse_end: got %0d expected 0", hit); end
    c_alien = 1'b1;
    cyc(1);
    c_alien = 1'b0;
    n_checks++;
    if (score !== 16'd130) begin n_fail++; $display("FAIL freeze_score: got %0d expected 130", score); end
    repeat (59) pulse_sof();
    n_checks++;
    if (state !== 3'd2) begin n_fail++; $display("FAIL freeze_59: got %0d expected 2", state); end
    pulse_sof();
    n_checks += 2;
    if (state !== 3'd1) begin n_fail++; $display("FAIL freeze_exit: got %0d expected 1", state); end
    if (lives !== 3'd2) begin n_fail++; $display("FAIL freeze_lives: got %0d expected 2", lives); end
  endtask
  task automatic test_last_life();
    pulse_sof();
    c_player = 1'b1;
    cyc(1);
    c_player = 1'b0;
    repeat (60) pulse_sof();
    n_checks += 2;
    if (lives !== 3'd1) begin n_fail++; $display("FAIL last_setup_lives: got %0d expected 1", lives); end
    if (state !== 3'd1) begin n_fail++; $display("FAIL last_setup_state: got %0d expected 1", state); end
    c_player = 1'b1;
    cyc(1);
    c_player = 1'b0;
    n_checks += 3;
    if (state !== 3'd4) begin n_fail++; $display("FAIL over_state: got %0d expected 4", state); end
    if (lives !== 3'd0) begin n_fail++; $display("FAIL over_lives: got %0d expected 0", lives); end
    if (hit !== 1'b1) begin n_fail++; $display("FAIL over_pulse: got %0d expected 1", hit); end
    pulse_sof();
    c_alien = 1'b1;
    cyc(1);
    c_alien = 1'b0;
    n_checks++;
    if (score !== 16'd130) begin n_fail++; $display("FAIL over_hold: got %0d expected 130", score); end
    press_start();
    n_checks += 5;
    if (score !== 16'd0) begin n_fail++; $display("FAIL restart_score: got %0d expected 0", score); end
    if (lives !== 3'd3) begin n_fail++; $display("FAIL restart_lives: got %0d expected 3", lives); end
    if (level !== 4'd1) begin n_fail++; $display("FAIL restart_level: got %0d expected 1", level); end
    if (aliens !== 6'd40) begin n_fail++; $display("FAIL restart_aliens: got %0d expected 40", aliens); end
    if (state !== 3'd1) begin n_fail++; $display("FAIL restart_state: got %0d expected 1", state); end
  endtask
  task automatic test_level_clear();
    resetN = 1'b0;
    cyc(1);
    resetN = 1'b1;
    cyc(1);
    press_start();
    pulse_sof();
    c_alien = 1'b1;
    cyc(1);
    c_alien = 1'b0;
    n_checks++;
    if (aliens2 !== 6'd1) begin n_fail++; $display("FAIL lc_first: got %0d expected 1", aliens2); end
    pulse_sof();
    c_alien = 1'b1;
    cyc(1);
    c_alien = 1'b0;
    n_checks += 2;
    if (state2 !== 3'd3) begin n_fail++; $display("FAIL lc_state: got %0d expected 3", state2); end
    if (aliens2 !== 6'd0) begin n_fail++; $display("FAIL lc_aliens0: got %0d expected 0", aliens2); end
    repeat (59) pulse_sof();
    n_checks += 2;
    if (state2 !== 3'd3) begin n_fail++; $display("FAIL lc_59: got %0d expected 3", state2); end
    if (level2 !== 4'd1) begin n_fail++; $display("FAIL lc_level_early: got %0d expected 1", level2); end
    sof = 1'b1;
    cyc(1);
    sof = 1'b0;
    n_checks += 4;
    if (level2 !== 4'd2) begin n_fail++; $display("FAIL lc_level: got %0d expected 2", level2); end
    if (aliens2 !== 6'd2) begin n_fail++; $display("FAIL lc_reload: got %0d expected 2", aliens2); end
    if (lvlup2 !== 1'b1) begin n_fail++; $display("FAIL lc_pulse: got %0d expected 1", lvlup2); end
    if (state2 !== 3'd1) begin n_fail++; $display("FAIL lc_exit: got %0d expected 1", state2); end
    cyc(1);
    n_checks++;
    if (lvlup2 !== 1'b0) begin n_fail++; $display("FAIL lc_pulse_end: got %0d expected 0", lvlup2); end
  endtask
  task automatic test_invasion();
    pulse_sof();
    inv = 1'b1;
    c_alien = 1'b1;
    cyc(1);
    inv = 1'b0;
    c_alien = 1'b0;
    n_checks += 3;
    if (state !== 3'd4) begin n_fail++; $display("FAIL inv_state: got %0d expected 4", state); end
    if (lives !== 3'd0) begin n_fail++; $display("FAIL inv_lives: got %0d expected 0", lives); end
    if (freeze !== 1'b1) begin n_fail++; $display("FAIL inv_freeze: got %0d expected 1", freeze); end
  endtask
  task automatic test_saturation();
    int exp_score;
    exp_score = 0;
    press_start();
    for (int i = 0; i < 656; i++) begin
      pulse_sof();
      c_ship = 1'b1;
      cyc(1);
      c_ship = 1'b0;
      exp_score = (exp_score + 100 > 65535) ? 65535 : exp_score + 100;
      if (i == 654) begin
        n_checks++;
        if (score !== 16'(exp_score)) begin n_fail++; $display("FAIL sat_near: got %0d expected %0d", score, exp_score); end
      end
    end
    n_checks++;
    if (score !== 16'hFFFF) begin n_fail++; $display("FAIL sat_clamp: got %0d expected 65535", score); end
    pulse_sof();
    c_alien = 1'b1;
    cyc(1);
    c_alien = 1'b0;
    n_checks += 2;
    if (score !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %0d expected 65535", score); end
    if (aliens !== 6'd39) begin n_fail++; $display("FAIL sat_aliens: got %0d expected 39", aliens); end
  endtask
  task automatic test_reset_in_freeze();
    pulse_sof();
    c_player = 1'b1;
    cyc(1);
    c_player = 1'b0;
    n_checks++;
    if (state !== 3'd2) begin n_fail++; $display("FAIL rf_enter: got %0d expected 2", state); end
    cyc(2);
    #2 resetN = 1'b0;
    #1;
    n_checks += 6;
    if (state !== 3'd0) begin n_fail++; $display("FAIL rf_state: got %0d expected 0", state); end
    if (score !== 16'd0) begin n_fail++; $display("FAIL rf_score: got %0d expected 0", score); end
    if (lives !== 3'd3) begin n_fail++; $display("FAIL rf_lives: got %0d expected 3", lives); end
    if (level !== 4'd1) begin n_fail++; $display("FAIL rf_level: got %0d expected 1", level); end
    if (aliens !== 6'd40) begin n_fail++; $display("FAIL rf_aliens: got %0d expected 40", aliens); end
    if (freeze !== 1'b1) begin n_fail++; $display("FAIL rf_freeze: got %0d expected 1", freeze); end
    cyc(1);
    resetN = 1'b1;
    cyc(1);
    press_start();
    n_checks++;
    if (state !== 3'd1) begin n_fail++; $display("FAIL rf_restart: got %0d expected 1", state); end
  endtask
  initial begin
    cyc(1);
    test_reset();
    test_start();
    test_alien_hold();
    test_simultaneous();
    test_player_freeze();
    test_last_life();
    test_level_clear();
    test_invasion();
    test_saturation();
    test_reset_in_freeze();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
